// File: rtl/adder_arbiter_if.sv
// Operand/request and result bundle between two clients and the shared adder arbiter.
interface adder_arbiter_if #(
  parameter int WIDTH = 3
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH:0]   sum;
  logic             busy;
  logic [7:0]       op_count;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, sum, busy, op_count
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, sum, busy, op_count
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two requesters.
// One operation every two cycles: capture in IDLE, add and report in CALC.
module adder_arbiter #(
  parameter int WIDTH   = 3,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [7:0]       count_q, count_d;
  logic             winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      owner_q <= 1'b0;
      prio_q  <= RR_INIT;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    sum_d   = sum_q;
    count_d = count_q;
    winner  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // A lone request wins outright; a tie goes to the priority holder.
          winner  = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          opA_d   = winner ? bus.a1 : bus.a0;
          opB_d   = winner ? bus.b1 : bus.b0;
          owner_d = winner;
          prio_d  = ~winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = {1'b0, opA_q} + {1'b0, opB_q};
        done0_d = ~owner_q;
        done1_d = owner_q;
        count_d = count_q + 8'd1;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.sum      = sum_q;
  assign bus.busy     = (state_q == CALC);
  assign bus.op_count = count_q;

endmodule
